// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and index helpers for the 8-point radix-2 DIT FFT.
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_STAGES = 3;
  localparam int W          = 25;
  localparam int C_TW       = 23170;
  localparam int C_SHIFT    = 15;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  function automatic int bit_rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // Upper-leg position of butterfly bf within a stage whose span is 2^stage.
  function automatic int bf_top(input int stage, input int bf);
    int half;
    half = 1 << stage;
    return (bf / half) * 2 * half + (bf % half);
  endfunction

  function automatic int twiddle_idx(input int stage, input int bf);
    int half;
    half = 1 << stage;
    return (bf % half) * ((FFT_N / 2) / half);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Registered radix-2 butterfly with fixed twiddle W8^TW_IDX; A' = A + B*W, B' = A - B*W.
// FFT_CORE_SCALE_EN: when defined, both outputs are halved (arithmetic shift) before registering.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int CW     = W,
  parameter int TW_IDX = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2*CW-1:0] a_i,
  input  logic [2*CW-1:0] b_i,
  output logic [2*CW-1:0] a_o,
  output logic [2*CW-1:0] b_o
);

  localparam int PW = CW + 18;
  localparam logic signed [PW-1:0] C_P   = PW'(C_TW);
  localparam logic signed [PW-1:0] RND_P = PW'(1 << (C_SHIFT - 1));

  logic signed [CW:0]   a_re, a_im, b_re, b_im;
  logic signed [CW:0]   s_re, s_im;
  logic signed [PW-1:0] p_re, p_im;
  logic        [CW-1:0] nb_re;
  logic signed [CW-1:0] t_re, t_im;
  logic signed [CW:0]   sum_re, sum_im, dif_re, dif_im;
  logic [2*CW-1:0]      a_d, b_d, a_q, b_q;
  logic                 unused_bits;

  assign a_re = {a_i[2*CW-1], a_i[2*CW-1:CW]};
  assign a_im = {a_i[CW-1], a_i[CW-1:0]};
  assign b_re = {b_i[2*CW-1], b_i[2*CW-1:CW]};
  assign b_im = {b_i[CW-1], b_i[CW-1:0]};

  always_comb begin
    s_re  = '0;
    s_im  = '0;
    nb_re = '0 - b_i[2*CW-1:CW];
    t_re  = b_i[2*CW-1:CW];
    t_im  = b_i[CW-1:0];
    case (TW_IDX)
      1: begin
        s_re = b_re + b_im;
        s_im = b_im - b_re;
      end
      3: begin
        s_re = b_im - b_re;
        s_im = -b_re - b_im;
      end
      default: ;
    endcase
    // Full-precision product, round-half-up, then back to Q0.
    p_re = (PW'(s_re) * C_P + RND_P) >>> C_SHIFT;
    p_im = (PW'(s_im) * C_P + RND_P) >>> C_SHIFT;
    case (TW_IDX)
      1, 3: begin
        t_re = p_re[CW-1:0];
        t_im = p_im[CW-1:0];
      end
      2: begin
        t_re = b_i[CW-1:0];
        t_im = nb_re;
      end
      default: ;
    endcase
    sum_re = a_re + {t_re[CW-1], t_re};
    sum_im = a_im + {t_im[CW-1], t_im};
    dif_re = a_re - {t_re[CW-1], t_re};
    dif_im = a_im - {t_im[CW-1], t_im};
`ifdef FFT_CORE_SCALE_EN
    a_d = {sum_re[CW:1], sum_im[CW:1]};
    b_d = {dif_re[CW:1], dif_im[CW:1]};
`else
    a_d = {sum_re[CW-1:0], sum_im[CW-1:0]};
    b_d = {dif_re[CW-1:0], dif_im[CW-1:0]};
`endif
  end

`ifdef FFT_CORE_SCALE_EN
  assign unused_bits = ^{p_re[PW-1:CW], p_im[PW-1:CW], sum_re[0], sum_im[0], dif_re[0], dif_im[0]};
`else
  assign unused_bits = ^{p_re[PW-1:CW], p_im[PW-1:CW], sum_re[CW], sum_im[CW], dif_re[CW], dif_im[CW]};
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: rtl/fft_core.sv
// Fully pipelined 8-point forward DFT: 3 registered radix-2 DIT stages, bit-reversal by wiring.
// FFT_CORE_SCALE_EN (optional): halve every butterfly output so X is divided by 8 overall.
module fft_core
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] input_signal  [0:7],
  output logic [DATA_WIDTH-1:0] output_signal [0:7],
  output logic                  valid_o
);

  localparam int CW = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] stage_w [0:FFT_STAGES][0:FFT_N-1];
  logic [FFT_STAGES-1:0] valid_d, valid_q;

  genvar gi, gs;

  generate
    for (gi = 0; gi < FFT_N; gi++) begin : g_bitrev
      assign stage_w[0][gi] = input_signal[bit_rev3(gi)];
    end

    for (gs = 0; gs < FFT_STAGES; gs++) begin : g_stage
      for (gi = 0; gi < FFT_N / 2; gi++) begin : g_bf
        localparam int TOP  = bf_top(gs, gi);
        localparam int HALF = 1 << gs;
        fft_butterfly #(
          .CW     (CW),
          .TW_IDX (twiddle_idx(gs, gi))
        ) u_bf (
          .clk_i (clk_i),
          .rst_i (rst_i),
          .a_i   (stage_w[gs][TOP]),
          .b_i   (stage_w[gs][TOP+HALF]),
          .a_o   (stage_w[gs+1][TOP]),
          .b_o   (stage_w[gs+1][TOP+HALF])
        );
      end
    end

    for (gi = 0; gi < FFT_N; gi++) begin : g_out
      assign output_signal[gi] = stage_w[FFT_STAGES][gi];
    end
  endgenerate

  // One token per pipeline stage tracks which stages hold post-reset data.
  always_comb begin
    valid_d = {valid_q[FFT_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q[FFT_STAGES-1];

endmodule

// File: tb/tb_fft_core.sv
// Directed self-checking bench for fft_core with hand-computed DFT bins.
module tb_fft_core;
  import fft_pkg::*;

  localparam int DW = 2 * W;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] in_sig  [0:7];
  logic [DW-1:0] out_sig [0:7];
  logic          valid_o;
  int            tests = 0;
  int            fails = 0;

  always #5 clk_i = ~clk_i;

  fft_core #(.DATA_WIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .input_signal  (in_sig),
    .output_signal (out_sig),
    .valid_o       (valid_o)
  );

  function automatic logic [DW-1:0] cx(input int re, input int im);
    cplx_t c;
    c.re = W'(re);
    c.im = W'(im);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all(input int re, input int im);
    for (int i = 0; i < 8; i++) in_sig[i] = cx(re, im);
  endtask

  task automatic chk_valid(input string tag, input logic exp);
    tests++;
    assert (valid_o === exp)
    else begin
      fails++;
      $error("FAIL %s: valid_o observed %b expected %b", tag, valid_o, exp);
    end
  endtask

  task automatic chk_bins(input string tag, input int er [8], input int ei [8]);
    logic [DW-1:0] exp;
    for (int k = 0; k < 8; k++) begin
      exp = cx(er[k], ei[k]);
      tests++;
      assert (out_sig[k] === exp)
      else begin
        fails++;
        $error("FAIL %s X[%0d]: observed re=%0d im=%0d expected re=%0d im=%0d", tag, k,
               $signed(out_sig[k][DW-1:W]), $signed(out_sig[k][W-1:0]), er[k], ei[k]);
      end
    end
    $display("[TB] %s: bins checked", tag);
  endtask

  initial begin
    rst_i = 1'b0;
    set_all(0, 0);
    tick(); tick(); tick();
    chk_bins("reset", '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    chk_valid("reset valid", 1'b0);

    // First vector after release: DC, sampled at the first edge with rst_i high.
    set_all(1, 0);
    rst_i = 1'b1;
    tick(); chk_valid("valid edge1", 1'b0);
    tick(); chk_valid("valid edge2", 1'b0);
    tick(); chk_valid("valid edge3", 1'b1);
`ifdef FFT_CORE_SCALE_EN
    chk_bins("dc scaled", '{1,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
`else
    chk_bins("dc", '{8,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});

    set_all(0, 0); in_sig[0] = cx(1, 0);
    tick(); tick(); tick();
    chk_bins("impulse", '{1,1,1,1,1,1,1,1}, '{0,0,0,0,0,0,0,0});

    set_all(0, 0); in_sig[1] = cx(1, 0);
    tick(); tick(); tick();
    chk_bins("shift1", '{1,1,0,-1,-1,-1,0,1}, '{0,-1,-1,-1,0,1,1,1});

    set_all(0, 0); in_sig[2] = cx(1, 0);
    tick(); tick(); tick();
    chk_bins("shift2", '{1,0,-1,0,1,0,-1,0}, '{0,-1,0,1,0,-1,0,1});

    for (int i = 0; i < 8; i++) in_sig[i] = cx((i % 2 == 0) ? 1 : -1, 0);
    tick(); tick(); tick();
    chk_bins("alternating", '{0,0,0,0,8,0,0,0}, '{0,0,0,0,0,0,0,0});

    set_all(0, 0); in_sig[0] = cx(-3, 1);
    tick(); tick(); tick();
    chk_bins("neg impulse", '{-3,-3,-3,-3,-3,-3,-3,-3}, '{1,1,1,1,1,1,1,1});

    set_all(0, 0); in_sig[1] = cx(-3, 1);
    tick(); tick(); tick();
    chk_bins("neg shift1", '{-3,-1,1,3,3,1,-1,-3}, '{1,3,3,1,-1,-3,-3,-1});

    set_all((1 << 24) - 1, 0);
    tick(); tick(); tick();
    chk_bins("overflow", '{-8,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});

    // Back-to-back vectors, one per clock.
    set_all(0, 0); in_sig[0] = cx(1, 0);
    tick();
    set_all(0, 0); in_sig[2] = cx(1, 0);
    tick();
    for (int i = 0; i < 8; i++) in_sig[i] = cx((i % 2 == 0) ? 1 : -1, 0);
    tick();
    chk_bins("pipe impulse", '{1,1,1,1,1,1,1,1}, '{0,0,0,0,0,0,0,0});
    set_all(0, 0); in_sig[1] = cx(1, 0);
    tick();
    chk_bins("pipe shift2", '{1,0,-1,0,1,0,-1,0}, '{0,-1,0,1,0,-1,0,1});
    tick();
    chk_bins("pipe alternating", '{0,0,0,0,8,0,0,0}, '{0,0,0,0,0,0,0,0});
    tick();
    chk_bins("pipe shift1", '{1,1,0,-1,-1,-1,0,1}, '{0,-1,-1,-1,0,1,1,1});
    chk_valid("pipe valid", 1'b1);

    // One-edge reset mid-stream flushes everything in flight.
    set_all(0, 0); in_sig[0] = cx(-3, 1);
    tick();
    set_all(5, 5);
    rst_i = 1'b0;
    tick();
    chk_bins("midreset", '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    chk_valid("midreset valid", 1'b0);
    rst_i = 1'b1;
    set_all(1, 0);
    tick(); chk_valid("rerelease edge1", 1'b0);
    for (int i = 0; i < 8; i++) in_sig[i] = cx((i % 2 == 0) ? 1 : -1, 0);
    tick(); chk_valid("rerelease edge2", 1'b0);
    tick(); chk_valid("rerelease edge3", 1'b1);
    chk_bins("rerelease dc", '{8,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    tick();
    chk_bins("rerelease alternating", '{0,0,0,0,8,0,0,0}, '{0,0,0,0,0,0,0,0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_core.md
FFT_CORE -- requirements
Module: fft_core

Interface
REQ-001 Parameter DATA_WIDTH, default 50, SHALL be the width of one packed complex sample and SHALL be even; W = DATA_WIDTH/2 = 25 bits per component.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be a synchronous, active-low reset.
REQ-004 input_signal  input  DATA_WIDTH x [0:7]  SHALL carry time samples x[0..7] in natural order; bits [DATA_WIDTH-1:W] hold the real part and bits [W-1:0] hold the imaginary part, both signed two's complement.
REQ-005 output_signal  output  DATA_WIDTH x [0:7]  SHALL carry frequency bins X[0..7] in natural order, packed in the same format as the input.
REQ-006 valid_o  output  1  SHALL flag that output_signal holds a transform of registered input; it may be left unconnected.

Function
REQ-007 The block SHALL compute X[k] = sum over n of x[n]*W8^(nk), with W8 = exp(-j2pi/8): a forward, unnormalised 8-point DFT.
REQ-008 Architecture SHALL be radix-2 decimation-in-time in 3 stages of 4 butterflies each (12 total), with bit-reversed input permutation done by wiring.
REQ-009 Each stage SHALL be registered, giving a fully pipelined core that accepts a new input vector every clock.
REQ-010 Latency SHALL be 3 clocks: a vector sampled at edge t SHALL appear on output_signal after edge t+3.
REQ-011 Butterfly: A' = A + B*W and B' = A - B*W, with component sums wrapping modulo 2^W (no saturation).
REQ-012 Twiddle handling:
- W8^0 is a pass-through.
- W8^2 is an exact swap/negate: (a+jb)(-j) = b - ja.
- W8^1 = ((a+b) + j(b-a))*C.
- W8^3 = ((b-a) + j(-a-b))*C.
REQ-013 C SHALL be the constant 23170 (round(2^15/sqrt2)); each product SHALL be computed on a (W+1)-bit sum at full precision, then 16384 added, then arithmetically shifted right 15, then truncated to W bits.
REQ-014 valid_o SHALL rise after the 3rd rising edge with rst_i high and stay high while rst_i stays high.

Reset
REQ-015 While rst_i=0 at a rising edge, all pipeline registers, output_signal[0..7] and valid_o SHALL become 0.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight vectors.
REQ-017 After release, the first valid output SHALL be the vector sampled at the first edge with rst_i=1.

Configuration
REQ-018 Macro FFT_CORE_SCALE_EN: when defined, each butterfly output SHALL be arithmetically shifted right by 1 (truncation) before registering, so X is divided by 8 overall; when undefined, no scaling is applied (REQ-011).

Structure
REQ-019 A shared package fft_pkg SHALL hold the FFT size 8, the stage count 3, the component width W, the constant C=23170 with shift 15, and a packed complex typedef with re/im fields.
REQ-020 One sub-module, fft_butterfly, SHALL implement one registered butterfly including its twiddle multiply; the twiddle index is selected by parameter, and the module honours FFT_CORE_SCALE_EN.

Verification
REQ-021 Impulse: x[0]=(1,0), others 0 -> X[k]=(1,0) for all k, 3 clocks after sampling.
REQ-022 DC: all x=(1,0) -> X[0]=(8,0), other bins 0; with FFT_CORE_SCALE_EN -> X[0]=(1,0).
REQ-023 Shifted impulse: x[1]=(1,0) -> X[0..7] = (1,0),(1,-1),(0,-1),(-1,-1),(-1,0),(-1,1),(0,1),(1,1).
REQ-024 Alternating: x[n]=(+1,0),(-1,0),... -> X[4]=(8,0), others 0; negative components such as (-3,1) round-trip through sign extension correctly.
REQ-025 Pipelining/reset: drive a new vector every clock, then drop rst_i for one edge mid-stream -> outputs and valid_o are 0 on the next edge; valid_o returns after 3 edges with rst_i high.
REQ-026 Overflow: all x=(2^24-1,0) -> X[0] real part wraps modulo 2^25 with no saturation (unscaled build).
